// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the two-input gate BIST checker.
package gate_bist_pkg;

    localparam int unsigned GATE_W  = 7;
    localparam int unsigned NUM_VEC = 4;

    localparam int unsigned IDX_NOT  = 0;
    localparam int unsigned IDX_AND  = 1;
    localparam int unsigned IDX_OR   = 2;
    localparam int unsigned IDX_XOR  = 3;
    localparam int unsigned IDX_XNOR = 4;
    localparam int unsigned IDX_NAND = 5;
    localparam int unsigned IDX_NOR  = 6;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference for the seven gate outputs given inputs A and B.
module gate_golden_model
    import gate_bist_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [GATE_W-1:0] expected
);

    always_comb begin
        expected           = '0;
        expected[IDX_NOT]  = ~a;
        expected[IDX_AND]  = a & b;
        expected[IDX_OR]   = a | b;
        expected[IDX_XOR]  = a ^ b;
        expected[IDX_XNOR] = ~(a ^ b);
        expected[IDX_NAND] = ~(a & b);
        expected[IDX_NOR]  = ~(a | b);
    end

endmodule

// File: rtl/gate_bist_checker.sv
// BIST controller: sweeps A/B over all four vectors, samples the gate block and
// accumulates mismatch statistics against the golden model.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              a_out,
    output logic              b_out,
    input  logic [GATE_W-1:0] gate_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [2:0]        err_count,
    output logic [GATE_W-1:0] err_mask,
    output logic [1:0]        first_fail_vec
);

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [1:0]        vec_q, vec_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              a_q, a_d, b_q, b_d;
    logic [GATE_W-1:0] sample_q, sample_d;
    logic [1:0]        cmp_vec_q, cmp_vec_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic              cmp_last_q, cmp_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [2:0]        err_count_q, err_count_d;
    logic [GATE_W-1:0] err_mask_q, err_mask_d;
    logic [1:0]        first_q, first_d;

    logic [GATE_W-1:0] golden;
    logic [GATE_W-1:0] mism;
    logic              accept;

    // Compare runs one cycle behind the sample, against the registered snapshot.
    gate_golden_model u_golden (
        .a        (cmp_vec_q[1]),
        .b        (cmp_vec_q[0]),
        .expected (golden)
    );

    assign mism   = sample_q ^ golden;
    assign accept = start && !busy_q && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sample_d    = sample_q;
        cmp_vec_d   = cmp_vec_q;
        cmp_vld_d   = 1'b0;
        cmp_last_d  = cmp_last_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_mask_d  = err_mask_q;
        first_d     = first_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d     = DRIVE;
                    vec_d       = 2'd0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    cnt_d       = RELOAD;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    err_mask_d  = '0;
                    first_d     = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                sample_d   = gate_in;
                cmp_vec_d  = vec_q;
                cmp_vld_d  = 1'b1;
                cmp_last_d = (vec_q == 2'd3);
                if (vec_q == 2'd3) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    a_d     = vec_d[1];
                    b_d     = vec_d[0];
                    cnt_d   = RELOAD;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cmp_vld_q) begin
            if (mism != '0) begin
                err_count_d = err_count_q + 3'd1;
                err_mask_d  = err_mask_q | mism;
                if (err_count_q == 3'd0) begin
                    first_d = cmp_vec_q;
                end
            end
            if (cmp_last_q) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_count_d == 3'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            sample_q    <= '0;
            cmp_vec_q   <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_mask_q  <= '0;
            first_q     <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sample_q    <= sample_d;
            cmp_vec_q   <= cmp_vec_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_last_q  <= cmp_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
            first_q     <= first_d;
        end
    end

    assign a_out          = a_q;
    assign b_out          = b_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign err_mask       = err_mask_q;
    assign first_fail_vec = first_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench: three checker instances (settle 2, 1, 4) driven by a faultable gate model.
module tb_gate_bist_checker;

    typedef struct {
        logic [6:0] stuck0;
        logic [6:0] stuck1;
        logic [6:0] inv;
        logic       retrig;
        logic [2:0] exp_cnt;
        logic [6:0] exp_mask;
        logic [1:0] exp_first;
        logic       exp_pass;
    } run_vec_t;

    typedef struct {
        logic       a;
        logic       b;
        logic [6:0] exp;
    } gold_vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [6:0] stuck0, stuck1, inv;

    logic       a_w    [3];
    logic       b_w    [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [2:0] cnt_w  [3];
    logic [6:0] mask_w [3];
    logic [1:0] ffv_w  [3];
    logic [6:0] gin_w  [3];

    int settle[3] = '{2, 1, 4};
    int checks = 0;
    int errors = 0;

    logic       ga, gb;
    logic [6:0] gold_out;

    // Independent truth table of the gate block (bits 6..0 = NOR NAND XNOR XOR OR AND NOT).
    function automatic logic [6:0] ref_gates(input logic a, input logic b);
        logic [1:0] v;
        v = {a, b};
        case (v)
            2'b00:   return 7'b1110001;
            2'b01:   return 7'b0101101;
            2'b10:   return 7'b0101100;
            default: return 7'b0010110;
        endcase
    endfunction

    assign gin_w[0] = ((ref_gates(a_w[0], b_w[0]) & ~stuck0) | stuck1) ^ inv;
    assign gin_w[1] = ((ref_gates(a_w[1], b_w[1]) & ~stuck0) | stuck1) ^ inv;
    assign gin_w[2] = ((ref_gates(a_w[2], b_w[2]) & ~stuck0) | stuck1) ^ inv;

    gate_bist_checker #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .a_out(a_w[0]), .b_out(b_w[0]),
        .gate_in(gin_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(cnt_w[0]), .err_mask(mask_w[0]), .first_fail_vec(ffv_w[0])
    );
    gate_bist_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .a_out(a_w[1]), .b_out(b_w[1]),
        .gate_in(gin_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(cnt_w[1]), .err_mask(mask_w[1]), .first_fail_vec(ffv_w[1])
    );
    gate_bist_checker #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .a_out(a_w[2]), .b_out(b_w[2]),
        .gate_in(gin_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(cnt_w[2]), .err_mask(mask_w[2]), .first_fail_vec(ffv_w[2])
    );

    gate_golden_model u_gold (
        .a        (ga),
        .b        (gb),
        .expected (gold_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s dut%0d a_out", tag, d), 32'(a_w[d]), 0);
            chk($sformatf("%s dut%0d b_out", tag, d), 32'(b_w[d]), 0);
            chk($sformatf("%s dut%0d busy", tag, d), 32'(busy_w[d]), 0);
            chk($sformatf("%s dut%0d done", tag, d), 32'(done_w[d]), 0);
            chk($sformatf("%s dut%0d pass", tag, d), 32'(pass_w[d]), 0);
            chk($sformatf("%s dut%0d err_count", tag, d), 32'(cnt_w[d]), 0);
            chk($sformatf("%s dut%0d err_mask", tag, d), 32'(mask_w[d]), 0);
            chk($sformatf("%s dut%0d first_fail_vec", tag, d), 32'(ffv_w[d]), 0);
        end
    endtask

    task automatic run_sweep(input run_vec_t r, input string tag);
        int t[3];
        int n;
        int ev;
        stuck0 = r.stuck0;
        stuck1 = r.stuck1;
        inv    = r.inv;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s dut%0d busy after start", tag, d), 32'(busy_w[d]), 1);
            chk($sformatf("%s dut%0d done after start", tag, d), 32'(done_w[d]), 0);
            chk($sformatf("%s dut%0d cleared count", tag, d), 32'(cnt_w[d]), 0);
            chk($sformatf("%s dut%0d cleared mask", tag, d), 32'(mask_w[d]), 0);
            chk($sformatf("%s dut%0d cleared first", tag, d), 32'(ffv_w[d]), 0);
        end
        t = '{-1, -1, -1};
        n = 0;
        while (n < 40 && (t[0] < 0 || t[1] < 0 || t[2] < 0)) begin
            @(posedge clk); #1;
            n++;
            for (int d = 0; d < 3; d++) begin
                if (t[d] < 0 && done_w[d] === 1'b1) begin
                    t[d] = n;
                    chk($sformatf("%s dut%0d busy at done", tag, d), 32'(busy_w[d]), 0);
                end
            end
            for (int d = 0; d < 2; d++) begin
                ev = n / (settle[d] + 1);
                if (ev > 3) ev = 3;
                chk($sformatf("%s dut%0d {a,b} edge %0d", tag, d, n),
                    32'({a_w[d], b_w[d]}), 32'(ev));
            end
            start = r.retrig && (n == 2 || n == 6);
        end
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s dut%0d done edge", tag, d), 32'(t[d]), 32'(4 * (settle[d] + 1) + 1));
            chk($sformatf("%s dut%0d err_count", tag, d), 32'(cnt_w[d]), 32'(r.exp_cnt));
            chk($sformatf("%s dut%0d err_mask", tag, d), 32'(mask_w[d]), 32'(r.exp_mask));
            chk($sformatf("%s dut%0d first_fail_vec", tag, d), 32'(ffv_w[d]), 32'(r.exp_first));
            chk($sformatf("%s dut%0d pass", tag, d), 32'(pass_w[d]), 32'(r.exp_pass));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        gold_vec_t gv[4];
        run_vec_t  rows[9];
        run_vec_t  clean;

        gv[0] = '{1'b0, 1'b0, 7'b1110001};
        gv[1] = '{1'b0, 1'b1, 7'b0101101};
        gv[2] = '{1'b1, 1'b0, 7'b0101100};
        gv[3] = '{1'b1, 1'b1, 7'b0010110};

        //         stuck0      stuck1      inv         rt    cnt   mask        first pass
        rows[0] = '{7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 3'd0, 7'b0000000, 2'd0, 1'b1};
        rows[1] = '{7'b0000010, 7'b0000000, 7'b0000000, 1'b0, 3'd1, 7'b0000010, 2'd3, 1'b0};
        rows[2] = '{7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 3'd0, 7'b0000000, 2'd0, 1'b1};
        rows[3] = '{7'b0000000, 7'b0000000, 7'b0001000, 1'b0, 3'd4, 7'b0001000, 2'd0, 1'b0};
        rows[4] = '{7'b1000000, 7'b0000000, 7'b0000000, 1'b0, 3'd1, 7'b1000000, 2'd0, 1'b0};
        rows[5] = '{7'b0000000, 7'b0000000, 7'b0000101, 1'b1, 3'd4, 7'b0000101, 2'd0, 1'b0};
        rows[6] = '{7'b0100000, 7'b0000000, 7'b0000000, 1'b0, 3'd3, 7'b0100000, 2'd0, 1'b0};
        rows[7] = '{7'b0000000, 7'b0000010, 7'b0000000, 1'b0, 3'd3, 7'b0000010, 2'd0, 1'b0};
        rows[8] = '{7'b0000000, 7'b0010000, 7'b0000000, 1'b0, 3'd2, 7'b0010000, 2'd1, 1'b0};
        clean   = rows[0];

        rst    = 1'b1;
        start  = 1'b0;
        stuck0 = '0;
        stuck1 = '0;
        inv    = '0;
        ga     = 1'b0;
        gb     = 1'b0;

        for (int i = 0; i < 4; i++) begin
            ga = gv[i].a;
            gb = gv[i].b;
            #1;
            chk($sformatf("golden model vec %0d", i), 32'(gold_out), 32'(gv[i].exp));
        end

        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_sweep(rows[i], $sformatf("row%0d", i));
        end

        // Reset during vector 10 with partial errors accumulated, then a clean rerun.
        stuck0 = '0;
        stuck1 = '0;
        inv    = 7'b0001000;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort dut0 {a,b} before reset", 32'({a_w[0], b_w[0]}), 2);
        chk("abort dut0 partial err_count", 32'(cnt_w[0]), 1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk_reset_values("abort");
        repeat (3) @(posedge clk);
        #1;
        chk("abort dut0 stays idle busy", 32'(busy_w[0]), 0);
        chk("abort dut0 stays idle a_out", 32'(a_w[0]), 0);
        run_sweep(clean, "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
- Synthesizable built-in self-test controller for the two-input logic-gate block.
- Drives the A/B inputs through all four vectors, waits a settle time, samples the seven gate outputs and compares them against a golden model.
- Reports pass/fail, an error count, a per-gate failure mask and the first failing vector.
- It is the checking end of the gate interface: it consumes gate responses rather than only producing stimulus. It sits between the gate block and a status register or LED bank.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a sweep when not busy
- a_out  out  1  A input driven to the gate block
- b_out  out  1  B input driven to the gate block
- gate_in  in  7  gate outputs; bit0 NOT(A), bit1 AND, bit2 OR, bit3 XOR, bit4 XNOR, bit5 NAND, bit6 NOR
- busy  out  1  high from the cycle after start until DONE is entered
- done  out  1  level; high in DONE until the next accepted start or rst
- pass  out  1  valid when done=1; 1 only if err_count==0
- err_count  out  3  number of vectors with at least one mismatching bit (0..4)
- err_mask  out  7  OR-accumulated per-gate mismatch bits over the sweep
- first_fail_vec  out  2  {A,B} of the first failing vector; 0 if none

Behaviour:
- Reset:
  - state=IDLE.
  - a_out=b_out=0.
  - busy=done=pass=0.
  - err_count=0, err_mask=0, first_fail_vec=0.
  - Reset mid-sweep aborts immediately to these values and discards all partial results.
- States are IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 -> DRIVE.
  - vec=0, a_out=vec[1], b_out=vec[0].
  - Clear err_count, err_mask, first_fail_vec.
  - busy=1, settle counter=SETTLE_CYCLES-1.
- DRIVE:
  - a_out/b_out stable.
  - Counter decrements each cycle.
  - When the counter is 0 -> SAMPLE. DRIVE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle): gate_in is registered and compared with golden(vec); mism = gate_in ^ golden.
  - If mism!=0: err_count+1 and err_mask |= mism. If err_count was 0, first_fail_vec=vec.
  - If vec==3 -> DONE.
  - Otherwise vec+1, a_out/b_out update, counter reloads -> DRIVE.
- DONE:
  - busy=0, done=1, pass=(err_count==0). Results are held.
  - start=1 clears the results and re-enters DRIVE exactly as from IDLE (done falls the same cycle).
- start is ignored while busy=1; no queuing.
- Vector order is 00, 01, 10, 11. Each vector occupies SETTLE_CYCLES+1 cycles.
- Latency: start sampled at edge 0 -> done first high after edge 4*(SETTLE_CYCLES+1)+1. This is edge 13 with the default.
- Golden for vector (A,B):
  - NOT = ~A
  - AND = A&B
  - OR = A|B
  - XOR = A^B
  - XNOR = ~(A^B)
  - NAND = ~(A&B)
  - NOR = ~(A|B)
- err_count cannot exceed 4, so no saturation logic is needed. All outputs are registered.

Decomposition:
- Package gate_bist_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE);
  - gate bit-index constants (IDX_NOT..IDX_NOR);
  - GATE_W=7 and NUM_VEC=4.
- Sub-module gate_golden_model: combinational; inputs A and B, output 7-bit expected vector. It is reused by the bench as the reference.

Test Plan:
- Correct gate model connected, SETTLE_CYCLES=2, start pulse -> done at edge 13, pass=1, err_count=0, err_mask=0000000, first_fail_vec=0.
- AND output stuck at 0 -> fails only on vector 11: err_count=1, err_mask=0000010, first_fail_vec=3, pass=0.
- XOR output inverted -> every vector fails: err_count=4, err_mask=0001000, first_fail_vec=0.
- rst asserted in DRIVE of vector 10 -> next cycle all outputs at reset values and state IDLE; a new start gives a clean full sweep with correct results.
- start pulsed again at cycles 3 and 7 while busy -> ignored, done still at edge 13; start in DONE after a failing run -> results cleared, the rerun with a correct model gives pass=1.
- SETTLE_CYCLES=1 -> a_out/b_out change every 2 cycles, done at edge 9; SETTLE_CYCLES=4 -> done at edge 21.
